// File: rtl/worker_result_arbiter.sv
// Round-robin arbiter funnelling NUM_WORKERS worker-result channels into one downstream port
// through a one-word holding register.
module worker_result_arbiter #(
  parameter int unsigned WORKER_RESULT_WIDTH = 32,
  parameter int unsigned NUM_WORKERS         = 4,
  parameter int unsigned GRANT_WIDTH         = $clog2(NUM_WORKERS)
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NUM_WORKERS-1:0]                     RECEIVE_WR_VALID,
  input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic [NUM_WORKERS-1:0]                     RECEIVE_WR_READY,
  output logic                                       SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]             SEND_WR_DATA,
  input  logic                                       SEND_WR_READY,
  output logic [GRANT_WIDTH-1:0]                     GRANT_ID,
  output logic [31:0]                                TRANSFER_COUNT
);

  typedef enum logic [1:0] {
    StArb,
    StAccept,
    StSend
  } state_e;

  state_e                         state_q;
  logic   [GRANT_WIDTH-1:0]       ptr_q;
  logic   [NUM_WORKERS-1:0]       ready_q;
  logic                           send_valid_q;
  logic   [WORKER_RESULT_WIDTH-1:0] send_data_q;
  logic   [GRANT_WIDTH-1:0]       grant_q;
  logic   [31:0]                  count_q;

  logic                           arb_found;
  logic   [GRANT_WIDTH-1:0]       arb_winner;
  logic   [GRANT_WIDTH-1:0]       ptr_next;
  int unsigned                    search_idx;

  // First requester at or after the pointer, wrapping explicitly so any NUM_WORKERS works.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    search_idx = 0;
    for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
      search_idx = int'(ptr_q) + i;
      if (search_idx >= NUM_WORKERS) begin
        search_idx = search_idx - NUM_WORKERS;
      end
      if (!arb_found && RECEIVE_WR_VALID[search_idx]) begin
        arb_found  = 1'b1;
        arb_winner = GRANT_WIDTH'(search_idx);
      end
    end
  end

  always_comb begin
    if (grant_q == GRANT_WIDTH'(NUM_WORKERS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_q + GRANT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StArb;
      ptr_q        <= '0;
      ready_q      <= '0;
      send_valid_q <= 1'b0;
      send_data_q  <= '0;
      grant_q      <= '0;
      count_q      <= '0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (arb_found) begin
            grant_q <= arb_winner;
            ready_q <= NUM_WORKERS'(1) << arb_winner;
            state_q <= StAccept;
          end else begin
            ready_q <= '0;
          end
        end
        StAccept: begin
          // A sender that drops VALID early keeps its grant until it reasserts.
          if (RECEIVE_WR_VALID[grant_q]) begin
            send_data_q  <= RECEIVE_WR_DATA[grant_q*WORKER_RESULT_WIDTH +: WORKER_RESULT_WIDTH];
            ready_q      <= '0;
            send_valid_q <= 1'b1;
            state_q      <= StSend;
          end
        end
        StSend: begin
          if (SEND_WR_READY) begin
            send_valid_q <= 1'b0;
            count_q      <= count_q + 32'd1;
            ptr_q        <= ptr_next;
            state_q      <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign RECEIVE_WR_READY = ready_q;
  assign SEND_WR_VALID    = send_valid_q;
  assign SEND_WR_DATA     = send_data_q;
  assign GRANT_ID         = grant_q;
  assign TRANSFER_COUNT   = count_q;

endmodule

// File: tb/tb_worker_result_arbiter.sv
// Directed bench for worker_result_arbiter: cycle table plus stall, early-drop and reset cases.
module tb_worker_result_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
  localparam int unsigned G = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] rv;
  logic [N*W-1:0] rd;
  logic [N-1:0] rr;
  logic         sv;
  logic [W-1:0] sd;
  logic         sr;
  logic [G-1:0] gid;
  logic [31:0]  cnt;

  int checks = 0;
  int errors = 0;

  worker_result_arbiter #(
    .WORKER_RESULT_WIDTH(W),
    .NUM_WORKERS        (N),
    .GRANT_WIDTH        (G)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .RECEIVE_WR_VALID(rv),
    .RECEIVE_WR_DATA (rd),
    .RECEIVE_WR_READY(rr),
    .SEND_WR_VALID   (sv),
    .SEND_WR_DATA    (sd),
    .SEND_WR_READY   (sr),
    .GRANT_ID        (gid),
    .TRANSFER_COUNT  (cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] valid;
    logic         srdy;
    logic [N-1:0] ready;
    logic         svalid;
    logic [W-1:0] data;
    logic [G-1:0] grant;
    logic [31:0]  count;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] e_rdy, input logic e_sv,
                            input logic [W-1:0] e_data, input logic [G-1:0] e_gid,
                            input logic [31:0] e_cnt);
    check({tag, " ready"}, 32'(rr), 32'(e_rdy));
    check({tag, " send_valid"}, 32'(sv), 32'(e_sv));
    check({tag, " send_data"}, 32'(sd), 32'(e_data));
    check({tag, " grant_id"}, 32'(gid), 32'(e_gid));
    check({tag, " count"}, cnt, e_cnt);
  endtask

  task automatic add(input logic [N-1:0] v, input logic s, input logic [N-1:0] r,
                     input logic esv, input logic [W-1:0] d, input logic [G-1:0] g,
                     input logic [31:0] c);
    vec_t e;
    e.valid  = v;
    e.srdy   = s;
    e.ready  = r;
    e.svalid = esv;
    e.data   = d;
    e.grant  = g;
    e.count  = c;
    vecs.push_back(e);
  endtask

  initial begin
    // Single request on channel 0.
    add(4'b0001, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 32'd0);
    add(4'b0001, 1'b1, 4'b0000, 1'b1, 8'hA0, 2'd0, 32'd0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0, 32'd1);
    // All four continuously valid, pointer starts at 1.
    add(4'b1111, 1'b1, 4'b0010, 1'b0, 8'hA0, 2'd1, 32'd1);
    add(4'b1111, 1'b1, 4'b0000, 1'b1, 8'hA1, 2'd1, 32'd1);
    add(4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA1, 2'd1, 32'd2);
    add(4'b1111, 1'b1, 4'b0100, 1'b0, 8'hA1, 2'd2, 32'd2);
    add(4'b1111, 1'b1, 4'b0000, 1'b1, 8'hA2, 2'd2, 32'd2);
    add(4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2, 32'd3);
    add(4'b1111, 1'b1, 4'b1000, 1'b0, 8'hA2, 2'd3, 32'd3);
    add(4'b1111, 1'b1, 4'b0000, 1'b1, 8'hA3, 2'd3, 32'd3);
    add(4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA3, 2'd3, 32'd4);
    add(4'b1111, 1'b1, 4'b0001, 1'b0, 8'hA3, 2'd0, 32'd4);
    add(4'b1111, 1'b1, 4'b0000, 1'b1, 8'hA0, 2'd0, 32'd4);
    add(4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0, 32'd5);
    // Grant 3, then only ch0/ch2: wrap to 0, then 2, then wrap to 0 again.
    add(4'b1000, 1'b1, 4'b1000, 1'b0, 8'hA0, 2'd3, 32'd5);
    add(4'b1000, 1'b1, 4'b0000, 1'b1, 8'hA3, 2'd3, 32'd5);
    add(4'b0101, 1'b1, 4'b0000, 1'b0, 8'hA3, 2'd3, 32'd6);
    add(4'b0101, 1'b1, 4'b0001, 1'b0, 8'hA3, 2'd0, 32'd6);
    add(4'b0101, 1'b1, 4'b0000, 1'b1, 8'hA0, 2'd0, 32'd6);
    add(4'b0101, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0, 32'd7);
    add(4'b0101, 1'b1, 4'b0100, 1'b0, 8'hA0, 2'd2, 32'd7);
    add(4'b0101, 1'b1, 4'b0000, 1'b1, 8'hA2, 2'd2, 32'd7);
    add(4'b0101, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2, 32'd8);
    add(4'b0101, 1'b1, 4'b0001, 1'b0, 8'hA2, 2'd0, 32'd8);
    add(4'b0101, 1'b1, 4'b0000, 1'b1, 8'hA0, 2'd0, 32'd8);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0, 32'd9);

    RST = 1'b1;
    rv  = '0;
    sr  = 1'b0;
    rd  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step();
    step();
    expect_out("reset", 4'b0000, 1'b0, 8'h00, 2'd0, 32'd0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      rv = vecs[i].valid;
      sr = vecs[i].srdy;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].ready, vecs[i].svalid, vecs[i].data,
                 vecs[i].grant, vecs[i].count);
    end

    // Downstream stall holding word B; new requests must not be granted meanwhile.
    rd[1*W +: W] = 8'hB5;
    rv = 4'b0010;
    sr = 1'b0;
    step();
    expect_out("stall grant", 4'b0010, 1'b0, 8'hA0, 2'd1, 32'd9);
    step();
    expect_out("stall load", 4'b0000, 1'b1, 8'hB5, 2'd1, 32'd9);
    rv = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      step();
      expect_out($sformatf("stall hold%0d", k), 4'b0000, 1'b1, 8'hB5, 2'd1, 32'd9);
    end
    rv = 4'b0000;
    sr = 1'b1;
    step();
    expect_out("stall release", 4'b0000, 1'b0, 8'hB5, 2'd1, 32'd10);
    step();
    expect_out("stall once", 4'b0000, 1'b0, 8'hB5, 2'd1, 32'd10);

    // Pointer is 2; ch0 wins by wrap, then drops VALID early and keeps READY.
    rv = 4'b0001;
    step();
    expect_out("drop grant", 4'b0001, 1'b0, 8'hB5, 2'd0, 32'd10);
    rv = 4'b0000;
    step();
    expect_out("drop wait", 4'b0001, 1'b0, 8'hB5, 2'd0, 32'd10);
    rv = 4'b0001;
    step();
    expect_out("drop accept", 4'b0000, 1'b1, 8'hA0, 2'd0, 32'd10);
    rv = 4'b0000;
    step();
    expect_out("drop send", 4'b0000, 1'b0, 8'hA0, 2'd0, 32'd11);

    // Reset while a word sits in the holding register.
    rd[2*W +: W] = 8'hC7;
    rv = 4'b0100;
    sr = 1'b0;
    step();
    expect_out("rst grant", 4'b0100, 1'b0, 8'hA0, 2'd2, 32'd11);
    step();
    expect_out("rst load", 4'b0000, 1'b1, 8'hC7, 2'd2, 32'd11);
    rv = 4'b0000;
    step();
    RST = 1'b1;
    step();
    expect_out("rst clear", 4'b0000, 1'b0, 8'h00, 2'd0, 32'd0);
    RST = 1'b0;
    sr = 1'b1;
    step();
    expect_out("rst idle", 4'b0000, 1'b0, 8'h00, 2'd0, 32'd0);
    // With the pointer back at 0, ch0 beats ch3.
    rd[0*W +: W] = 8'h5A;
    rv = 4'b1001;
    step();
    expect_out("post grant", 4'b0001, 1'b0, 8'h00, 2'd0, 32'd0);
    step();
    expect_out("post accept", 4'b0000, 1'b1, 8'h5A, 2'd0, 32'd0);
    rv = 4'b0000;
    step();
    expect_out("post send", 4'b0000, 1'b0, 8'h5A, 2'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
